// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants and helpers for the cascaded up/down counter.
// Imported by the digit slice and the counter top.
package bcd_updown_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  // Out-of-range nibbles are clamped so a digit never leaves 0..9.
  function automatic logic [BCD_W-1:0] bcd_sat(
    input logic [BCD_W-1:0] v
  );
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle for the BCD up/down counter.
// The master drives the controls; the slave returns count and flags.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);

  logic                  enable;
  logic                  up_dn;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   Q;
  logic                  tc;
  logic                  wrap;

  modport master (
    output enable,
    output up_dn,
    output clear,
    output load,
    output load_val,
    input  Q,
    input  tc,
    input  wrap
  );

  modport slave (
    input  enable,
    input  up_dn,
    input  clear,
    input  load,
    input  load_val,
    output Q,
    output tc,
    output wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: clear/load/step with at_term flagging the carry
// (up, digit 9) or borrow (down, digit 0) condition.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  input  logic             step_en,
  input  logic             up_dn,
  output logic [BCD_W-1:0] d,
  output logic             at_term
);

  assign at_term = up_dn ? (d == BCD_MAX)
                         : (d == BCD_MIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d <= BCD_MIN;
    end else if (clear) begin
      d <= BCD_MIN;
    end else if (load) begin
      d <= bcd_sat(load_d);
    end else if (step_en) begin
      if (up_dn)
        d <= at_term ? BCD_MIN : d + 4'd1;
      else
        d <= at_term ? BCD_MAX : d - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter: digit chaining, terminal count,
// and the registered wrap pulse.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic                    clk,
  input logic                    reset,
  bcd_updown_counter_if.slave    bus
);

  logic [DIGITS-1:0]       term;
  logic [BCD_W*DIGITS-1:0] q;
  logic                    wrap_q;

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad
    $error("bcd_updown_counter: DIGITS out of range");
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic st;

    // A digit steps only when every lower digit is at its terminal value.
    if (k == 0) begin : g_lsd
      assign st = bus.enable;
    end else begin : g_upper
      assign st = bus.enable & (&term[k-1:0]);
    end

    bcd_digit u_dig (
      .clk     (clk),
      .reset   (reset),
      .clear   (bus.clear),
      .load    (bus.load),
      .load_d  (bus.load_val[BCD_W*k +: BCD_W]),
      .step_en (st),
      .up_dn   (bus.up_dn),
      .d       (q[BCD_W*k +: BCD_W]),
      .at_term (term[k])
    );
  end

  assign bus.Q  = q;
  assign bus.tc = bus.enable & (&term);

  // Clear and load override counting, so they also suppress wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wrap_q <= 1'b0;
    else if (bus.clear | bus.load)
      wrap_q <= 1'b0;
    else
      wrap_q <= bus.tc;
  end

  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter at DIGITS = 1, 2 and 8,
// all three driven from one shared stimulus stream.
module tb_bcd_updown_counter;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic        ud    = 1'b0;
  logic        clr   = 1'b0;
  logic        ld    = 1'b0;
  logic [31:0] lv    = '0;

  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(1)) if1 ();
  bcd_updown_counter_if #(.DIGITS(2)) if2 ();
  bcd_updown_counter_if #(.DIGITS(8)) if8 ();

  assign if1.enable   = en;
  assign if1.up_dn    = ud;
  assign if1.clear    = clr;
  assign if1.load     = ld;
  assign if1.load_val = lv[3:0];

  assign if2.enable   = en;
  assign if2.up_dn    = ud;
  assign if2.clear    = clr;
  assign if2.load     = ld;
  assign if2.load_val = lv[7:0];

  assign if8.enable   = en;
  assign if8.up_dn    = ud;
  assign if8.clear    = clr;
  assign if8.load     = ld;
  assign if8.load_val = lv;

  bcd_updown_counter #(.DIGITS(1)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  bcd_updown_counter #(.DIGITS(2)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  bcd_updown_counter #(.DIGITS(8)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    string       tag;
    logic [63:0] q;
    logic        w;
  } sb_t;

  sb_t    sbq[$];
  longint mv[3];
  bit     mw[3];
  int     nd[3] = '{1, 2, 8};

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint p10(int n);
    longint r = 1;
    for (int j = 0; j < n; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [63:0] to_bcd(longint v, int n);
    logic [63:0] r = '0;
    longint      t = v;
    for (int j = 0; j < n; j++) begin
      r[4*j +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint load_model(logic [31:0] v, int n);
    longint r = 0;
    for (int j = 0; j < n; j++) begin
      logic [3:0] dg;
      dg = v[4*j +: 4];
      if (dg > 4'd9) dg = 4'd9;
      r = r + longint'(dg) * p10(j);
    end
    return r;
  endfunction

  function automatic logic [63:0] get_q(int i);
    case (i)
      0:       return 64'(if1.Q);
      1:       return 64'(if2.Q);
      default: return 64'(if8.Q);
    endcase
  endfunction

  function automatic logic get_w(int i);
    case (i)
      0:       return if1.wrap;
      1:       return if2.wrap;
      default: return if8.wrap;
    endcase
  endfunction

  function automatic logic get_tc(int i);
    case (i)
      0:       return if1.tc;
      1:       return if2.tc;
      default: return if8.tc;
    endcase
  endfunction

  task automatic check_now(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s d%0d q", tag, nd[i]), get_q(i),
          to_bcd(mv[i], nd[i]));
      chk($sformatf("%s d%0d wrap", tag, nd[i]),
          64'(get_w(i)), 64'(mw[i]));
    end
  endtask

  task automatic step(string tag, bit e, bit u, bit c, bit l,
                      logic [31:0] v);
    en  = e;
    ud  = u;
    clr = c;
    ld  = l;
    lv  = v;
    #1;
    for (int i = 0; i < 3; i++) begin
      longint mx;
      bit     etc;
      sb_t    s;
      mx  = p10(nd[i]) - 1;
      etc = e && (u ? (mv[i] == mx) : (mv[i] == 0));
      chk($sformatf("%s d%0d tc", tag, nd[i]),
          64'(get_tc(i)), 64'(etc));
      if (c) begin
        mv[i] = 0;
        mw[i] = 0;
      end else if (l) begin
        mv[i] = load_model(v, nd[i]);
        mw[i] = 0;
      end else if (e) begin
        mw[i] = etc;
        if (u) mv[i] = (mv[i] == mx) ? 0 : mv[i] + 1;
        else   mv[i] = (mv[i] == 0) ? mx : mv[i] - 1;
      end else begin
        mw[i] = 0;
      end
      s.idx = i;
      s.tag = tag;
      s.q   = to_bcd(mv[i], nd[i]);
      s.w   = mw[i];
      sbq.push_back(s);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      sb_t s;
      s = sbq.pop_front();
      chk($sformatf("%s d%0d q", s.tag, nd[s.idx]),
          get_q(s.idx), s.q);
      chk($sformatf("%s d%0d wrap", s.tag, nd[s.idx]),
          64'(get_w(s.idx)), 64'(s.w));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      mw[i] = 0;
    end

    #12;
    check_now("por");
    reset = 1'b1;

    step("rel_hold", 0, 1, 0, 0, 32'h0);
    step("ld37", 0, 1, 0, 1, 32'h37);
    step("up38", 1, 1, 0, 0, 32'h0);

    #3;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      mw[i] = 0;
    end
    #1;
    check_now("arst");
    #2;
    reset = 1'b1;

    step("rel2_hold", 0, 1, 0, 0, 32'h0);
    step("first_up", 1, 1, 0, 0, 32'h0);
    step("clr", 0, 0, 1, 0, 32'h0);
    step("first_dn", 1, 0, 0, 0, 32'h0);
    step("dn_hold", 0, 0, 0, 0, 32'h0);

    step("clr100", 0, 1, 1, 0, 32'h0);
    repeat (100) step("up100", 1, 1, 0, 0, 32'h0);

    step("ld10", 0, 0, 0, 1, 32'h10);
    repeat (12) step("dn12", 1, 0, 0, 0, 32'h0);

    step("ld45", 0, 1, 0, 1, 32'h45);
    repeat (20) step("hold20", 0, 1, 0, 0, 32'h0);
    step("reen", 1, 1, 0, 0, 32'h0);

    step("ld58", 0, 1, 0, 1, 32'h58);
    step("clr_ld_en", 1, 1, 1, 1, 32'hFA);
    step("ld_fa", 0, 1, 0, 1, 32'hFA);

    step("ld50", 0, 1, 0, 1, 32'h50);
    step("dir_up", 1, 1, 0, 0, 32'h0);
    step("dir_dn", 1, 0, 0, 0, 32'h0);
    step("dir_dn2", 1, 0, 0, 0, 32'h0);
    step("dir_up2", 1, 1, 0, 0, 32'h0);

    step("clr_full", 0, 1, 1, 0, 32'h0);
    repeat (12) step("full_up", 1, 1, 0, 0, 32'h0);
    step("ld_hi", 0, 1, 0, 1, 32'h99999995);
    repeat (8) step("hi_up", 1, 1, 0, 0, 32'h0);
    step("ld_all9", 0, 1, 0, 1, 32'h99999999);
    step("wrap_all", 1, 1, 0, 0, 32'h0);
    step("after_wrap", 1, 1, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
